spike_count_argmax: RTL and testbench
=====================================

Name: spike_count_argmax

Overview:
- Downstream of the SNN core's final hidden layer: consumes the per-timestep output spike vector and accumulates one spike counter per output neuron.
- After the simulation completes, a sequential scan finds the winning neuron (maximum count).
- Exposes the winner index, the winner count and per-neuron counter readback to the AXI register/memory map (spike counter memory, MEM_CFG select 3).

Parameters:
- NUM_OUTPUTS, 100, number of output neurons (last hidden layer size).
- OUTPUT_SPIKE_ADDR_BITS, 7, index width; must satisfy 2**OUTPUT_SPIKE_ADDR_BITS >= NUM_OUTPUTS.
- MAX_TIMESTEPS_BITS, 7, timestep counter width of the core.
- COUNT_WIDTH, MAX_TIMESTEPS_BITS+1, per-neuron counter width.

Ports:
- clk  in  1  system clock (S_AXI_ACLK domain).
- rst  in  1  synchronous, active-high reset.
- clear  in  1  one-cycle pulse: zero all counters, drop result.
- spike_valid  in  1  spike_vec holds one timestep's output spikes.
- spike_vec  in  NUM_OUTPUTS  bit n = neuron n spiked this timestep.
- sim_done  in  1  one-cycle pulse from core: last timestep issued; start argmax.
- rd_addr  in  OUTPUT_SPIKE_ADDR_BITS  counter readback index.
- rd_data  out  COUNT_WIDTH  registered counter value for rd_addr.
- busy  out  1  high while scanning.
- result_valid  out  1  winner outputs are valid.
- winner_idx  out  OUTPUT_SPIKE_ADDR_BITS  index of the max-count neuron.
- winner_count  out  COUNT_WIDTH  count of the winner.
- tie  out  1  another neuron equals winner_count.

Behaviour:
- Reset (rst=1 at posedge): all counters 0; state IDLE; busy=0, result_valid=0, winner_idx=0, winner_count=0, tie=0, rd_data=0.
- States: IDLE, SCAN, DONE.
- IDLE/DONE accumulation:
  - On spike_valid=1, every counter n with spike_vec[n]=1 increments by 1 at the next edge.
  - All neurons update in the same cycle; back-to-back spike_valid is supported every cycle.
- Accumulation while in DONE clears result_valid in the same edge and moves the state to IDLE; the stale result is no longer claimed.
- sim_done in IDLE or DONE:
  - Go to SCAN; busy=1 next cycle; result_valid=0.
  - Scan index starts at 0; best index and best count reset to 0; tie=0.
- SCAN, one neuron per cycle at index i:
  - count[i] > best: best <- i, count; tie <- 0.
  - count[i] == best and i != 0: tie <- 1.
  - Strict greater-than, so the lowest index wins ties.
  - After i = NUM_OUTPUTS-1: go to DONE, busy=0, result_valid=1, winner outputs updated.
  - Latency: sim_done to result_valid = NUM_OUTPUTS+1 cycles.
- During SCAN: spike_valid is ignored (counters frozen); sim_done is ignored.
- All counters zero: winner_idx=0, winner_count=0, tie=1 (when NUM_OUTPUTS>1).
- clear, in any state: counters 0, state IDLE, busy=0, result_valid=0, tie=0; winner_idx and winner_count are held.
- Priority at the same edge: rst > clear > sim_done > spike_valid.
  - clear with spike_valid: clear wins; that timestep's spikes are not counted.
  - sim_done with spike_valid in IDLE: spikes counted first; the scan sees the updated counts (the scan starts reading the next cycle).
- Readback: rd_data <- count[rd_addr] at every edge (1-cycle latency), in all states. rd_addr >= NUM_OUTPUTS returns 0.
- Counter overflow: see Optional Feature.

Optional Feature:
- Macro SPIKE_COUNT_SATURATE_EN.
- Defined: counters saturate at 2**COUNT_WIDTH-1; further spikes leave them unchanged.
- Undefined: counters wrap modulo 2**COUNT_WIDTH; no overflow indication.

Test Plan:
- Reset, then read all 100 addresses -> rd_data=0 for each; busy=0, result_valid=0.
- spike_vec bit 5 set for 10 cycles, bit 42 set for 7 cycles, then sim_done -> busy for 100 cycles; result_valid at cycle 101; winner_idx=5, winner_count=10, tie=0; rd_addr=42 returns 7.
- Neurons 3 and 9 each spike 4 times, then sim_done -> winner_idx=3, winner_count=4, tie=1.
- Assert clear at the same edge as spike_valid (all bits set) -> all counters read 0, result_valid=0, state IDLE.
- Neuron 0 spikes 300 times with COUNT_WIDTH=8:
  - Macro defined -> count 255.
  - Macro undefined -> count 44.
- Mid-SCAN (cycle 50): pulse spike_valid and sim_done -> counters unchanged; scan completes at the original cycle; result reflects the pre-scan counts.

Source files
------------

// File: rtl/spike_count_argmax.sv
// spike_count_argmax
//   Accumulates one spike counter per output neuron from the SNN core's final
//   layer. On sim_done, a sequential scan visits one neuron per cycle and
//   selects the neuron with the highest count. Lowest index wins ties, and a
//   tie flag reports when another neuron shares the maximum. Counters can be
//   read back through a registered port.
//
//   Optional feature macro: SPIKE_COUNT_SATURATE_EN
//     defined   : counters saturate at 2**COUNT_WIDTH-1
//     undefined : counters wrap modulo 2**COUNT_WIDTH
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   clear          pulse: zero counters, drop result (winner outputs held)
//   spike_valid    spike_vec carries one timestep of output spikes
//   spike_vec      bit n = neuron n spiked
//   sim_done       pulse: start argmax scan
//   rd_addr        counter readback index
//   rd_data        registered count[rd_addr] (0 when out of range)
//   busy           scan in progress
//   result_valid   winner outputs are valid
//   winner_idx     index of max-count neuron
//   winner_count   count of the winner
//   tie            another neuron equals winner_count
module spike_count_argmax #(
  parameter int NUM_OUTPUTS            = 100,
  parameter int OUTPUT_SPIKE_ADDR_BITS = 7,
  parameter int MAX_TIMESTEPS_BITS     = 7,
  parameter int COUNT_WIDTH            = MAX_TIMESTEPS_BITS + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              spike_valid,
  input  logic [NUM_OUTPUTS-1:0]            spike_vec,
  input  logic                              sim_done,
  input  logic [OUTPUT_SPIKE_ADDR_BITS-1:0] rd_addr,
  output logic [COUNT_WIDTH-1:0]            rd_data,
  output logic                              busy,
  output logic                              result_valid,
  output logic [OUTPUT_SPIKE_ADDR_BITS-1:0] winner_idx,
  output logic [COUNT_WIDTH-1:0]            winner_count,
  output logic                              tie
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [OUTPUT_SPIKE_ADDR_BITS-1:0] LAST_IDX =
    OUTPUT_SPIKE_ADDR_BITS'(NUM_OUTPUTS - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic [COUNT_WIDTH-1:0]            count_q [NUM_OUTPUTS];
  logic [COUNT_WIDTH-1:0]            count_d [NUM_OUTPUTS];
  logic [1:0]                        state_q, state_d;
  logic [OUTPUT_SPIKE_ADDR_BITS-1:0] scan_idx_q, scan_idx_d;
  logic [OUTPUT_SPIKE_ADDR_BITS-1:0] best_idx_q, best_idx_d;
  logic [COUNT_WIDTH-1:0]            best_cnt_q, best_cnt_d;
  logic                              scan_tie_q, scan_tie_d;
  logic                              result_valid_q, result_valid_d;
  logic [OUTPUT_SPIKE_ADDR_BITS-1:0] winner_idx_q, winner_idx_d;
  logic [COUNT_WIDTH-1:0]            winner_count_q, winner_count_d;
  logic                              tie_q, tie_d;
  logic [COUNT_WIDTH-1:0]            rd_data_q, rd_data_d;

  // Single scan step: candidate at scan_idx_q against the running best.
  logic [COUNT_WIDTH-1:0]            cur_cnt;
  logic                              step_gt, step_eq;
  logic [OUTPUT_SPIKE_ADDR_BITS-1:0] nxt_best_idx;
  logic [COUNT_WIDTH-1:0]            nxt_best_cnt;
  logic                              nxt_tie;

  always_comb begin
    cur_cnt      = count_q[scan_idx_q];
    step_gt      = cur_cnt > best_cnt_q;
    // Index 0 is compared against the initial best of 0 and is not a tie.
    step_eq      = (cur_cnt == best_cnt_q) && (scan_idx_q != '0);
    nxt_best_idx = step_gt ? scan_idx_q : best_idx_q;
    nxt_best_cnt = step_gt ? cur_cnt : best_cnt_q;
    nxt_tie      = step_gt ? 1'b0 : (step_eq ? 1'b1 : scan_tie_q);
  end

  always_comb begin
    count_d        = count_q;
    state_d        = state_q;
    scan_idx_d     = scan_idx_q;
    best_idx_d     = best_idx_q;
    best_cnt_d     = best_cnt_q;
    scan_tie_d     = scan_tie_q;
    result_valid_d = result_valid_q;
    winner_idx_d   = winner_idx_q;
    winner_count_d = winner_count_q;
    tie_d          = tie_q;

    if (clear) begin
      for (int unsigned n = 0; n < NUM_OUTPUTS; n++) count_d[n] = '0;
      state_d        = IDLE;
      result_valid_d = 1'b0;
      tie_d          = 1'b0;
    end else if (state_q == SCAN) begin
      best_idx_d = nxt_best_idx;
      best_cnt_d = nxt_best_cnt;
      scan_tie_d = nxt_tie;
      if (scan_idx_q == LAST_IDX) begin
        state_d        = DONE;
        result_valid_d = 1'b1;
        winner_idx_d   = nxt_best_idx;
        winner_count_d = nxt_best_cnt;
        tie_d          = nxt_tie;
      end else begin
        scan_idx_d = scan_idx_q + 1'b1;
      end
    end else begin
      // IDLE or DONE: spikes are counted before any scan start so a
      // same-edge sim_done scans the updated counts.
      if (spike_valid) begin
        for (int unsigned n = 0; n < NUM_OUTPUTS; n++) begin
          if (spike_vec[n]) begin
`ifdef SPIKE_COUNT_SATURATE_EN
            if (count_q[n] != CNT_MAX) count_d[n] = count_q[n] + 1'b1;
`else
            count_d[n] = count_q[n] + 1'b1;
`endif
          end
        end
        state_d        = IDLE;
        result_valid_d = 1'b0;
      end
      if (sim_done) begin
        state_d        = SCAN;
        result_valid_d = 1'b0;
        scan_idx_d     = '0;
        best_idx_d     = '0;
        best_cnt_d     = '0;
        scan_tie_d     = 1'b0;
        tie_d          = 1'b0;
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    if (32'(rd_addr) < NUM_OUTPUTS) rd_data_d = count_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned n = 0; n < NUM_OUTPUTS; n++) count_q[n] <= '0;
      state_q        <= IDLE;
      scan_idx_q     <= '0;
      best_idx_q     <= '0;
      best_cnt_q     <= '0;
      scan_tie_q     <= 1'b0;
      result_valid_q <= 1'b0;
      winner_idx_q   <= '0;
      winner_count_q <= '0;
      tie_q          <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      count_q        <= count_d;
      state_q        <= state_d;
      scan_idx_q     <= scan_idx_d;
      best_idx_q     <= best_idx_d;
      best_cnt_q     <= best_cnt_d;
      scan_tie_q     <= scan_tie_d;
      result_valid_q <= result_valid_d;
      winner_idx_q   <= winner_idx_d;
      winner_count_q <= winner_count_d;
      tie_q          <= tie_d;
      rd_data_q      <= rd_data_d;
    end
  end

  assign busy         = (state_q == SCAN);
  assign result_valid = result_valid_q;
  assign winner_idx   = winner_idx_q;
  assign winner_count = winner_count_q;
  assign tie          = tie_q;
  assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_spike_count_argmax.sv
module tb_spike_count_argmax;
  localparam int N  = 100;
  localparam int AW = 7;
  localparam int CW = 8;
  localparam int CMOD = 1 << CW;

  logic          clk = 1'b0;
  logic          rst, clear, spike_valid, sim_done;
  logic [N-1:0]  spike_vec;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rd_data, winner_count;
  logic          busy, result_valid, tie;
  logic [AW-1:0] winner_idx;

  spike_count_argmax #(
    .NUM_OUTPUTS(N), .OUTPUT_SPIKE_ADDR_BITS(AW),
    .MAX_TIMESTEPS_BITS(7), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .spike_valid(spike_valid),
    .spike_vec(spike_vec), .sim_done(sim_done), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .result_valid(result_valid),
    .winner_idx(winner_idx), .winner_count(winner_count), .tie(tie)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: counts as plain ints, argmax computed in one pass at
  // sim_done, result published NUM_OUTPUTS cycles later.
  int mc [N];
  int scan_left;
  int pend_idx, pend_cnt, pend_tie;
  int exp_busy, exp_rv, exp_widx, exp_wcnt, exp_tie, exp_rd;
  bit chk_en = 0;

  function automatic int bump(input int c);
`ifdef SPIKE_COUNT_SATURATE_EN
    return (c == CMOD - 1) ? c : c + 1;
`else
    return (c + 1) % CMOD;
`endif
  endfunction

  always @(posedge clk) begin
    exp_rd = (int'(rd_addr) < N) ? mc[int'(rd_addr)] : 0;
    if (rst) begin
      foreach (mc[n]) mc[n] = 0;
      scan_left = 0; exp_busy = 0; exp_rv = 0; exp_widx = 0;
      exp_wcnt = 0; exp_tie = 0; exp_rd = 0;
    end else if (clear) begin
      foreach (mc[n]) mc[n] = 0;
      scan_left = 0; exp_busy = 0; exp_rv = 0; exp_tie = 0;
    end else if (scan_left > 0) begin
      scan_left--;
      if (scan_left == 0) begin
        exp_busy = 0; exp_rv = 1;
        exp_widx = pend_idx; exp_wcnt = pend_cnt; exp_tie = pend_tie;
      end
    end else begin
      if (spike_valid) begin
        for (int n = 0; n < N; n++) if (spike_vec[n]) mc[n] = bump(mc[n]);
        exp_rv = 0;
      end
      if (sim_done) begin
        int best, nbest;
        best = -1; pend_idx = 0; nbest = 0;
        for (int n = 0; n < N; n++) if (mc[n] > best) begin best = mc[n]; pend_idx = n; end
        for (int n = 0; n < N; n++) if (mc[n] == best) nbest++;
        pend_cnt = best; pend_tie = (nbest > 1);
        scan_left = N; exp_busy = 1; exp_rv = 0; exp_tie = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy", int'(busy), exp_busy);
      cmp("result_valid", int'(result_valid), exp_rv);
      cmp("winner_idx", int'(winner_idx), exp_widx);
      cmp("winner_count", int'(winner_count), exp_wcnt);
      cmp("tie", int'(tie), exp_tie);
      cmp("rd_data", int'(rd_data), exp_rd);
    end
  end

  // Drive one cycle of inputs at a negedge and advance to the next negedge.
  task automatic cyc(input logic sv, input logic [N-1:0] v, input logic sd,
                     input logic cl, input logic [AW-1:0] a);
    spike_valid = sv; spike_vec = v; sim_done = sd; clear = cl; rd_addr = a;
    @(negedge clk);
  endtask

  // Returns cycles from the sim_done cycle until result_valid, and busy count.
  task automatic wait_result(output int lat, output int nbusy);
    lat = 1; nbusy = 0;
    while (!result_valid && lat < 300) begin
      if (busy) nbusy++;
      cyc(0, '0, 0, 0, '0);
      lat++;
    end
    if (!result_valid) cmp("scan_timeout", 0, 1);
  endtask

  logic [N-1:0] v;
  logic [N-1:0] ones;
  int lat, nbusy;

  initial begin
    ones = '1;
    rst = 1; clear = 0; spike_valid = 0; sim_done = 0; spike_vec = '0; rd_addr = '0;
    @(negedge clk); chk_en = 1;
    @(negedge clk);
    rst = 0;

    // Reset readback
    for (int a = 0; a < N; a++) begin
      cyc(0, '0, 0, 0, AW'(a));
      cmp("reset_rd", int'(rd_data), 0);
    end
    cmp("reset_busy", int'(busy), 0);
    cmp("reset_rv", int'(result_valid), 0);

    // Neuron 5 x10, neuron 42 x7
    for (int i = 0; i < 10; i++) begin
      v = '0; v[5] = 1'b1; if (i < 7) v[42] = 1'b1;
      cyc(1, v, 0, 0, '0);
    end
    cyc(0, '0, 1, 0, '0);
    wait_result(lat, nbusy);
    cmp("latency", lat, 101);
    cmp("busy_cycles", nbusy, 100);
    cmp("t2_idx", int'(winner_idx), 5);
    cmp("t2_cnt", int'(winner_count), 10);
    cmp("t2_tie", int'(tie), 0);
    cyc(0, '0, 0, 0, AW'(42));
    cmp("rd42", int'(rd_data), 7);
    cyc(0, '0, 0, 0, AW'(127));
    cmp("rd_oob", int'(rd_data), 0);

    // All zero -> tie
    cyc(0, '0, 0, 1, '0);
    cyc(0, '0, 1, 0, '0);
    wait_result(lat, nbusy);
    cmp("zero_idx", int'(winner_idx), 0);
    cmp("zero_cnt", int'(winner_count), 0);
    cmp("zero_tie", int'(tie), 1);

    // Neurons 3 and 9 x4 each
    for (int i = 0; i < 4; i++) begin
      v = '0; v[3] = 1'b1; v[9] = 1'b1;
      cyc(1, v, 0, 0, '0);
    end
    cyc(0, '0, 1, 0, '0);
    wait_result(lat, nbusy);
    cmp("t3_idx", int'(winner_idx), 3);
    cmp("t3_cnt", int'(winner_count), 4);
    cmp("t3_tie", int'(tie), 1);

    // clear wins over spike_valid; winner outputs held
    cyc(1, ones, 0, 1, '0);
    cmp("clr_rv", int'(result_valid), 0);
    cmp("clr_busy", int'(busy), 0);
    cmp("clr_widx_held", int'(winner_idx), 3);
    cyc(0, '0, 0, 0, AW'(3));
    cmp("clr_rd3", int'(rd_data), 0);

    // Overflow: neuron 0 x300
    for (int i = 0; i < 300; i++) begin
      v = '0; v[0] = 1'b1;
      cyc(1, v, 0, 0, '0);
    end
    cyc(0, '0, 0, 0, '0);
`ifdef SPIKE_COUNT_SATURATE_EN
    cmp("ovf_rd0", int'(rd_data), 255);
`else
    cmp("ovf_rd0", int'(rd_data), 44);
`endif

    // Mid-scan spike_valid and sim_done are ignored
    cyc(0, '0, 0, 1, '0);
    for (int i = 0; i < 6; i++) begin
      v = '0; v[20] = 1'b1; if (i < 3) v[60] = 1'b1;
      cyc(1, v, 0, 0, '0);
    end
    cyc(0, '0, 1, 0, '0);
    for (int i = 0; i < 49; i++) cyc(0, '0, 0, 0, '0);
    cyc(1, ones, 1, 0, '0);
    lat = 51;
    while (!result_valid && lat < 300) begin cyc(0, '0, 0, 0, '0); lat++; end
    cmp("mid_latency", lat, 101);
    cmp("mid_idx", int'(winner_idx), 20);
    cmp("mid_cnt", int'(winner_count), 6);
    cyc(0, '0, 0, 0, AW'(0));
    cmp("mid_rd0", int'(rd_data), 0);

    // Randomized traffic
    cyc(0, '0, 0, 1, '0);
    for (int i = 0; i < 3000; i++) begin
      v = '0;
      if ($urandom_range(0, 1) == 0)
        for (int b = 0; b < N; b++) v[b] = ($urandom_range(0, 15) == 0);
      else
        v[$urandom_range(0, 7)] = 1'b1;
      cyc(($urandom_range(0, 2) != 0), v, ($urandom_range(0, 60) == 0),
          ($urandom_range(0, 700) == 0), AW'($urandom_range(0, 127)));
    end
    cyc(0, '0, 1, 0, '0);
    wait_result(lat, nbusy);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
